// File: rtl/pipeline_debug_sequencer_if.sv
// pipeline_debug_sequencer_if: host byte link between the UART wrappers and the debug sequencer
interface pipeline_debug_sequencer_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;

    // Host side: drives command bytes and TX acceptance, consumes dump bytes
    modport master (
        output i_rx_data,
        output i_rx_valid,
        output i_tx_ready,
        input  o_tx_data,
        input  o_tx_valid
    );

    // Sequencer side
    modport slave (
        input  i_rx_data,
        input  i_rx_valid,
        input  i_tx_ready,
        output o_tx_data,
        output o_tx_valid
    );
endinterface

// File: rtl/pipeline_debug_sequencer.sv
// pipeline_debug_sequencer: byte-command loader, run/step controller and state dumper for the MIPS pipeline
module pipeline_debug_sequencer #(
    parameter int INST_MEM_ADDR_WIDTH = 9,
    parameter int DATA_MEM_ADDR_WIDTH = 8
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    pipeline_debug_sequencer_if.slave      host,
    output logic                           o_halt,
    output logic                           o_write_instruction_flag,
    output logic [31:0]                    o_instruction_to_write,
    output logic [INST_MEM_ADDR_WIDTH-1:0] o_address_to_write_inst,
    input  logic [63:0]                    i_IF_ID_latch,
    input  logic [138:0]                   i_ID_EX_latch,
    input  logic [75:0]                    i_EX_MEM_latch,
    input  logic [70:0]                    i_MEM_WB_latch,
    output logic [4:0]                     o_reg_read,
    input  logic [31:0]                    i_reg_content,
    output logic [DATA_MEM_ADDR_WIDTH-1:0] o_mem_read_addr,
    input  logic [31:0]                    i_mem_content,
    input  logic                           i_program_end
);
    // Latches padded to whole bytes: 8 + 18 + 10 + 9 = 45 bytes
    localparam int SNAP_BITS = 360;
    localparam logic [5:0] SNAP_BYTES = 6'd45;
    localparam logic [INST_MEM_ADDR_WIDTH-1:0] INST_STEP = INST_MEM_ADDR_WIDTH'(4);
    localparam logic [DATA_MEM_ADDR_WIDTH-1:0] MEM_STEP = DATA_MEM_ADDR_WIDTH'(4);

    typedef enum logic [3:0] {
        IDLE, LOAD, LOAD_WR, RUN, STEP, SNAP, TX_LATCH,
        RD_REG, TX_REG, RD_MEM, TX_MEM, TX_END
    } state_t;

    state_t                         state_q;
    logic                           halt_q;
    logic                           tx_valid_q;
    logic [7:0]                     tx_data_q;
    logic                           wr_q;
    logic [31:0]                    inst_q;
    logic [INST_MEM_ADDR_WIDTH-1:0] inst_addr_q;
    logic [4:0]                     reg_idx_q;
    logic [DATA_MEM_ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]                    word_q;
    logic [SNAP_BITS-1:0]           snap_q;
    logic [5:0]                     cnt_q;
    logic                           settle_q;

    logic                 accept_d;
    logic [31:0]          load_word_d;
    logic [SNAP_BITS-1:0] snap_d;
    logic                 last_inst_d;
    logic                 last_mem_d;

    assign accept_d    = tx_valid_q & host.i_tx_ready;
    assign load_word_d = {word_q[23:0], host.i_rx_data};
    assign snap_d      = {i_IF_ID_latch, 5'b0, i_ID_EX_latch, 4'b0, i_EX_MEM_latch, 1'b0, i_MEM_WB_latch};
    assign last_inst_d = &inst_addr_q[INST_MEM_ADDR_WIDTH-1:2];
    assign last_mem_d  = &mem_addr_q[DATA_MEM_ADDR_WIDTH-1:2];

    assign host.o_tx_data          = tx_data_q;
    assign host.o_tx_valid         = tx_valid_q;
    assign o_halt                  = halt_q;
    assign o_write_instruction_flag = wr_q;
    assign o_instruction_to_write  = inst_q;
    assign o_address_to_write_inst = inst_addr_q;
    assign o_reg_read              = reg_idx_q;
    assign o_mem_read_addr         = mem_addr_q;

    // Command FSM; an accepted TX byte drops valid unless the state presents the next one
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            halt_q      <= 1'b1;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            wr_q        <= 1'b0;
            inst_q      <= 32'h0;
            inst_addr_q <= '0;
            reg_idx_q   <= 5'd0;
            mem_addr_q  <= '0;
            word_q      <= 32'h0;
            snap_q      <= '0;
            cnt_q       <= 6'd0;
            settle_q    <= 1'b0;
        end else begin
            if (accept_d) tx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (host.i_rx_valid) begin
                        if (host.i_rx_data == 8'h4C) begin
                            inst_addr_q <= '0;
                            cnt_q       <= 6'd0;
                            state_q     <= LOAD;
                        end else if (host.i_rx_data == 8'h43 || host.i_rx_data == 8'h53) begin
                            if (i_program_end) begin
                                state_q <= SNAP;
                            end else begin
                                halt_q  <= 1'b0;
                                state_q <= (host.i_rx_data == 8'h43) ? RUN : STEP;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (host.i_rx_valid) begin
                        word_q <= load_word_d;
                        if (cnt_q == 6'd3) begin
                            inst_q  <= load_word_d;
                            wr_q    <= 1'b1;
                            cnt_q   <= 6'd0;
                            state_q <= LOAD_WR;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                LOAD_WR: begin
                    wr_q        <= 1'b0;
                    inst_addr_q <= inst_addr_q + INST_STEP;
                    if (&inst_q || last_inst_d) begin
                        tx_data_q  <= 8'h4C;
                        tx_valid_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                RUN: begin
                    if (i_program_end) begin
                        halt_q  <= 1'b1;
                        state_q <= SNAP;
                    end
                end
                STEP: begin
                    halt_q  <= 1'b1;
                    state_q <= SNAP;
                end
                SNAP: begin
                    snap_q     <= snap_d << 8;
                    tx_data_q  <= snap_d[SNAP_BITS-1 -: 8];
                    tx_valid_q <= 1'b1;
                    cnt_q      <= 6'd1;
                    state_q    <= TX_LATCH;
                end
                TX_LATCH: begin
                    if (accept_d) begin
                        if (cnt_q == SNAP_BYTES) begin
                            cnt_q   <= 6'd0;
                            state_q <= RD_REG;
                        end else begin
                            tx_data_q  <= snap_q[SNAP_BITS-1 -: 8];
                            snap_q     <= snap_q << 8;
                            tx_valid_q <= 1'b1;
                            cnt_q      <= cnt_q + 6'd1;
                        end
                    end
                end
                RD_REG: begin
                    settle_q <= !settle_q;
                    if (settle_q) begin
                        word_q     <= {i_reg_content[23:0], 8'h00};
                        tx_data_q  <= i_reg_content[31:24];
                        tx_valid_q <= 1'b1;
                        cnt_q      <= 6'd1;
                        state_q    <= TX_REG;
                    end
                end
                TX_REG: begin
                    if (accept_d) begin
                        if (cnt_q == 6'd4) begin
                            cnt_q     <= 6'd0;
                            reg_idx_q <= reg_idx_q + 5'd1;
                            state_q   <= (&reg_idx_q) ? RD_MEM : RD_REG;
                        end else begin
                            tx_data_q  <= word_q[31:24];
                            word_q     <= {word_q[23:0], 8'h00};
                            tx_valid_q <= 1'b1;
                            cnt_q      <= cnt_q + 6'd1;
                        end
                    end
                end
                RD_MEM: begin
                    settle_q <= !settle_q;
                    if (settle_q) begin
                        word_q     <= {i_mem_content[23:0], 8'h00};
                        tx_data_q  <= i_mem_content[31:24];
                        tx_valid_q <= 1'b1;
                        cnt_q      <= 6'd1;
                        state_q    <= TX_MEM;
                    end
                end
                TX_MEM: begin
                    if (accept_d) begin
                        if (cnt_q == 6'd4) begin
                            cnt_q      <= 6'd0;
                            mem_addr_q <= mem_addr_q + MEM_STEP;
                            if (last_mem_d) begin
                                tx_data_q  <= {7'b0, i_program_end};
                                tx_valid_q <= 1'b1;
                                state_q    <= TX_END;
                            end else begin
                                state_q <= RD_MEM;
                            end
                        end else begin
                            tx_data_q  <= word_q[31:24];
                            word_q     <= {word_q[23:0], 8'h00};
                            tx_valid_q <= 1'b1;
                            cnt_q      <= cnt_q + 6'd1;
                        end
                    end
                end
                TX_END: begin
                    if (accept_d) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_debug_sequencer.sv
// tb_pipeline_debug_sequencer: directed stimulus with a queue scoreboard for dump bytes and write strobes
module tb_pipeline_debug_sequencer;
    localparam int IAW = 9;
    localparam int DAW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic halt, wr_flag;
    logic [31:0] wr_inst;
    logic [IAW-1:0] wr_addr;
    logic [63:0] if_id = 64'h0123456789ABCDEF;
    logic [138:0] id_ex = {3'b101, {17{8'h5A}}};
    logic [75:0] ex_mem = {12'hABC, 64'h1122334455667788};
    logic [70:0] mem_wb = {7'h7F, 64'hCAFEF00DCAFEF00D};
    logic [4:0] reg_read;
    logic [31:0] reg_content = 32'h0;
    logic [DAW-1:0] mem_addr;
    logic [31:0] mem_content = 32'h0;
    logic program_end = 1'b0;
    logic bp_en = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    int checks = 0;
    int failures = 0;
    int halt_low = 0;

    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    logic [7:0] log_a[$];
    logic [IAW-1:0] waddr_q[$];
    logic [31:0] wdata_q[$];

    always #5 clk = ~clk;

    pipeline_debug_sequencer_if host();

    pipeline_debug_sequencer #(
        .INST_MEM_ADDR_WIDTH(IAW),
        .DATA_MEM_ADDR_WIDTH(DAW)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .host(host),
        .o_halt(halt),
        .o_write_instruction_flag(wr_flag),
        .o_instruction_to_write(wr_inst),
        .o_address_to_write_inst(wr_addr),
        .i_IF_ID_latch(if_id),
        .i_ID_EX_latch(id_ex),
        .i_EX_MEM_latch(ex_mem),
        .i_MEM_WB_latch(mem_wb),
        .o_reg_read(reg_read),
        .i_reg_content(reg_content),
        .o_mem_read_addr(mem_addr),
        .i_mem_content(mem_content),
        .i_program_end(program_end)
    );

    function automatic logic [31:0] reg_val(input logic [4:0] r);
        return (r == 5'd5) ? 32'hDEADBEEF : {8'hC0, 3'b0, r, 8'h5A, 3'b0, r};
    endfunction

    function automatic logic [31:0] mem_val(input logic [DAW-1:0] a);
        return {8'hA5, a, ~a, 8'h3C};
    endfunction

    function automatic logic [7:0] at(input int i);
        return (i < log_q.size()) ? log_q[i] : 8'hxx;
    endfunction

    // Register file and data memory modelled as registered read ports
    always @(posedge clk) begin
        reg_content <= reg_val(reg_read);
        mem_content <= mem_val(mem_addr);
    end

    // TX acceptance: always ready, or pseudo-random when backpressure is enabled
    always @(posedge clk) begin
        #1;
        host.i_tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a TX byte or write strobe is presented
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) check("tx_hold", host.o_tx_data, prev_data);
            if (host.o_tx_valid && host.i_tx_ready) begin
                log_q.push_back(host.o_tx_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_extra: got %0h, expected no byte", host.o_tx_data);
                end else begin
                    check($sformatf("tx_byte%0d", log_q.size()), host.o_tx_data, exp_q.pop_front());
                end
            end
            prev_stall <= host.o_tx_valid && !host.i_tx_ready;
            prev_data  <= host.o_tx_data;
            if (wr_flag) begin
                if (waddr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_extra: got strobe addr %0h data %0h, expected none", wr_addr, wr_inst);
                end else begin
                    check("wr_addr", wr_addr, waddr_q.pop_front());
                    check("wr_data", wr_inst, wdata_q.pop_front());
                end
            end
            if (!halt) halt_low++;
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        host.i_rx_data  = b;
        host.i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        host.i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send(w[31-8*b -: 8]);
    endtask

    task automatic push_dump(input logic end_flag);
        logic [359:0] s;
        logic [31:0] v;
        s = {if_id, 5'b0, id_ex, 4'b0, ex_mem, 1'b0, mem_wb};
        for (int i = 0; i < 45; i++) exp_q.push_back(s[359-8*i -: 8]);
        for (int r = 0; r < 32; r++) begin
            v = reg_val(5'(r));
            for (int b = 0; b < 4; b++) exp_q.push_back(v[31-8*b -: 8]);
        end
        for (int k = 0; k < 64; k++) begin
            v = mem_val(DAW'(4 * k));
            for (int b = 0; b < 4; b++) exp_q.push_back(v[31-8*b -: 8]);
        end
        exp_q.push_back({7'b0, end_flag});
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() + waddr_q.size()) != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size() + waddr_q.size()), 64'd0);
        exp_q.delete();
        waddr_q.delete();
        wdata_q.delete();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int diff;
        host.i_rx_data  = 8'h00;
        host.i_rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_halt", halt, 1'b1);
        check("rst_tx_valid", host.o_tx_valid, 1'b0);
        check("rst_tx_data", host.o_tx_data, 8'h00);
        check("rst_wr_flag", wr_flag, 1'b0);
        check("rst_wr_inst", wr_inst, 32'h0);
        check("rst_wr_addr", wr_addr, 9'h0);
        check("rst_reg_read", reg_read, 5'd0);
        check("rst_mem_addr", mem_addr, 8'h0);
        rst_n = 1'b1;

        // Short load ending in the halt instruction
        waddr_q.push_back(9'h000); wdata_q.push_back(32'h20010005);
        waddr_q.push_back(9'h004); wdata_q.push_back(32'hFFFFFFFF);
        exp_q.push_back(8'h4C);
        send(8'h4C);
        send_word(32'h20010005);
        send_word(32'hFFFFFFFF);
        wait_drain("load", 200);
        check("load_next_addr", wr_addr, 9'h008);

        // Fill every slot; the last write wraps the address
        send(8'h4C);
        for (int i = 0; i < 128; i++) begin
            waddr_q.push_back(IAW'(4 * i));
            wdata_q.push_back({8'h12, 8'h34, 8'(i), 8'h56});
            send_word({8'h12, 8'h34, 8'(i), 8'h56});
        end
        exp_q.push_back(8'h4C);
        wait_drain("cap", 200);
        check("cap_wrap_addr", wr_addr, 9'h000);

        // Single step with free-flowing TX
        halt_low = 0;
        log_q.delete();
        push_dump(1'b0);
        send(8'h53);
        wait_drain("step", 3000);
        check("step_halt_low", 64'(halt_low), 64'd1);
        check("step_len", 64'(log_q.size()), 64'd430);
        check("step_ifid_first", at(0), 8'h01);
        check("step_ifid_last", at(7), 8'hEF);
        check("step_idex_top", at(8), 8'h05);
        check("step_end", at(429), 8'h00);
        log_a = log_q;

        // Same step under random backpressure
        bp_en = 1'b1;
        log_q.delete();
        push_dump(1'b0);
        send(8'h53);
        wait_drain("bp", 6000);
        bp_en = 1'b0;
        diff = (log_q.size() == log_a.size()) ? 0 : 1;
        for (int i = 0; i < log_q.size() && i < log_a.size(); i++) if (log_q[i] !== log_a[i]) diff++;
        check("bp_stream_diffs", 64'(diff), 64'd0);
        check("bp_r5_b0", at(65), 8'hDE);
        check("bp_r5_b1", at(66), 8'hAD);
        check("bp_r5_b2", at(67), 8'hBE);
        check("bp_r5_b3", at(68), 8'hEF);

        // Free run until the pipeline reports the end of the program
        halt_low = 0;
        log_q.delete();
        push_dump(1'b1);
        send(8'h43);
        repeat (50) @(posedge clk);
        #1;
        program_end = 1'b1;
        wait_drain("run", 3000);
        check("run_halt_low", 64'(halt_low), 64'd51);
        check("run_end", at(429), 8'h01);

        // Program already ended: dump without releasing halt
        halt_low = 0;
        log_q.delete();
        push_dump(1'b1);
        send(8'h43);
        wait_drain("run2", 3000);
        check("run2_halt_low", 64'(halt_low), 64'd0);
        check("run2_len", 64'(log_q.size()), 64'd430);
        program_end = 1'b0;

        // Reset in the middle of a dump, then a clean step
        push_dump(1'b0);
        send(8'h53);
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_halt", halt, 1'b1);
        check("mid_rst_tx_valid", host.o_tx_valid, 1'b0);
        check("mid_rst_tx_data", host.o_tx_data, 8'h00);
        check("mid_rst_reg_read", reg_read, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        halt_low = 0;
        log_q.delete();
        push_dump(1'b0);
        send(8'h53);
        wait_drain("post_rst", 3000);
        check("post_rst_len", 64'(log_q.size()), 64'd430);
        check("post_rst_halt_low", 64'(halt_low), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
